// File: rtl/zf_host_to_stream_slot_ctrl_pkg.sv
// Shared register map, status layout and FSM encoding for the host-to-stream
// buffer address feeder.
package zf_host_to_stream_slot_ctrl_pkg;

    localparam int SR_H2S_PUSH = 0;
    localparam int SR_H2S_CTRL = 1;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam int ST_OVERFLOW_BIT = 31;
    localparam int ST_BUSY_BIT     = 30;
    localparam int ST_ENABLE_BIT   = 29;
    localparam int ST_OCC_LSB      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } h2s_state_t;

    // Buffers are 8-byte aligned in DDR; low address bits are discarded.
    function automatic logic [31:0] align8(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/zf_host_to_stream_slot_ctrl_axi_fifo_short.sv
// Small FIFO with a registered output stage: a written word becomes visible on
// o_tvalid one cycle after it lands in storage. occupied counts both stages.
module axi_fifo_short #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [SIZE:0]    occupied
);

    localparam int DEPTH = 1 << SIZE;
    localparam int CW    = SIZE + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE-1:0]  wr_ptr;
    logic [SIZE-1:0]  rd_ptr;
    logic [SIZE:0]    mem_cnt;
    logic             push;
    logic             load;

    assign occupied = mem_cnt + CW'(o_tvalid);
    assign i_tready = (occupied != CW'(DEPTH));
    assign push     = i_tvalid && i_tready;
    // Refill the output stage whenever it is empty or being consumed this cycle.
    assign load     = (mem_cnt != '0) && (!o_tvalid || o_tready);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            o_tvalid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + SIZE'(1);
            if (load)
                rd_ptr <= rd_ptr + SIZE'(1);
            mem_cnt <= mem_cnt + CW'(push) - CW'(load);
            if (load)
                o_tvalid <= 1'b1;
            else if (o_tready)
                o_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= i_tdata;
        if (load)
            o_tdata <= mem[rd_ptr];
    end

endmodule

// File: rtl/zf_host_to_stream_slot_ctrl.sv
// Queues host-posted DDR buffer addresses and hands them one at a time to the
// read engine; counts completions, pulses irq and exposes a status word.
module zf_host_to_stream_slot_ctrl
    import zf_host_to_stream_slot_ctrl_pkg::*;
#(
    parameter int BASE      = 0,
    parameter int FIFO_SIZE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    output logic [31:0] mem_addr,
    output logic        mem_valid,
    input  logic        mem_ack,
    output logic        irq,
    output logic [31:0] status
);

    localparam logic [7:0] PUSH_ADDR = 8'(BASE + SR_H2S_PUSH);
    localparam logic [7:0] CTRL_ADDR = 8'(BASE + SR_H2S_CTRL);

    h2s_state_t         state;
    h2s_state_t         state_nxt;
    logic               enable;
    logic               overflow;
    logic [15:0]        done_count;
    logic               push_wr;
    logic               ctrl_wr;
    logic               clear;
    logic               launch;
    logic               ack_done;
    logic               busy;
    logic [31:0]        fifo_head;
    logic               fifo_vld;
    logic               fifo_rdy;
    logic [FIFO_SIZE:0] occupancy;

    assign push_wr = set_stb && (set_addr == PUSH_ADDR);
    assign ctrl_wr = set_stb && (set_addr == CTRL_ADDR);
    assign clear   = ctrl_wr && set_data[CTRL_CLEAR_BIT];

    axi_fifo_short #(
        .WIDTH (32),
        .SIZE  (FIFO_SIZE)
    ) addr_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .i_tdata  (align8(set_data)),
        .i_tvalid (push_wr),
        .i_tready (fifo_rdy),
        .o_tdata  (fifo_head),
        .o_tvalid (fifo_vld),
        .o_tready (launch),
        .occupied (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && fifo_vld) state_nxt = BUSY;
            BUSY:    if (mem_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DONE holds mem_valid low for a cycle so the engine re-arms cleanly.
    always_comb begin
        launch    = (state == IDLE) && enable && fifo_vld;
        ack_done  = (state == BUSY) && mem_ack;
        mem_valid = (state == BUSY);
        irq       = (state == DONE);
        busy      = (state != IDLE);
    end

    // Clear does not touch the FSM: an in-flight buffer cannot be cancelled.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable     <= 1'b0;
            overflow   <= 1'b0;
            done_count <= 16'd0;
            mem_addr   <= 32'd0;
        end else begin
            if (ctrl_wr)
                enable <= set_data[CTRL_EN_BIT];
            if (clear)
                overflow <= 1'b0;
            else if (push_wr && !fifo_rdy)
                overflow <= 1'b1;
            if (clear)
                done_count <= 16'd0;
            else if (ack_done)
                done_count <= done_count + 16'd1;
            if (launch)
                mem_addr <= fifo_head;
        end
    end

    always_comb begin
        status                                = '0;
        status[ST_OVERFLOW_BIT]               = overflow;
        status[ST_BUSY_BIT]                   = busy;
        status[ST_ENABLE_BIT]                 = enable;
        status[ST_OCC_LSB +: 8]               = 8'(occupancy);
        status[15:0]                          = done_count;
    end

endmodule

// File: tb/tb_zf_host_to_stream_slot_ctrl.sv
// Randomized self-checking bench for zf_host_to_stream_slot_ctrl against a
// queue-based model of the host-visible behaviour.
module tb_zf_host_to_stream_slot_ctrl;

    localparam int BASE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic        mem_ack;
    logic        irq;
    logic [31:0] status;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model_q[$];
    logic [15:0] model_done;
    bit          model_ovf;
    bit          model_en;

    zf_host_to_stream_slot_ctrl #(
        .BASE      (BASE),
        .FIFO_SIZE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_ack   (mem_ack),
        .irq       (irq),
        .status    (status)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        return {model_ovf, 1'b0, model_en, 5'b00000, 8'(model_q.size()), model_done};
    endfunction

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        cyc();
        set_stb  = 1'b0;
    endtask

    task automatic host_push(input logic [31:0] d);
        write_reg(8'(BASE), d);
        if (model_q.size() < 16)
            model_q.push_back({d[31:3], 3'b000});
        else
            model_ovf = 1'b1;
    endtask

    task automatic host_ctrl(input bit en, input bit clr);
        write_reg(8'(BASE + 1), {30'd0, clr, en});
        model_en = en;
        if (clr) begin
            model_q.delete();
            model_ovf  = 1'b0;
            model_done = 16'd0;
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_done = 16'd0;
        model_ovf  = 1'b0;
        model_en   = 1'b0;
    endtask

    // Waits for a launch, checks it against the model head, holds a random time, acks.
    task automatic serve_one(input bit check_gap);
        int          low;
        logic [31:0] exp_a;
        logic [31:0] a0;
        bit          unstable;
        low = 0;
        unstable = 1'b0;
        while (mem_valid !== 1'b1 && low < 100) begin
            low++;
            cyc();
        end
        tests_run++;
        if (mem_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL launch_timeout: mem_valid=%b expected 1", mem_valid);
            return;
        end
        if (check_gap) begin
            tests_run++;
            if (low < 2) begin
                tests_failed++;
                $display("FAIL valid_gap: low cycles=%0d expected >=2", low);
            end
        end
        exp_a = 32'hDEAD_BEE8;
        if (model_q.size() > 0)
            exp_a = model_q.pop_front();
        tests_run++;
        if (mem_addr !== exp_a) begin
            tests_failed++;
            $display("FAIL launch_addr: mem_addr=%h expected %h", mem_addr, exp_a);
        end
        a0 = mem_addr;
        repeat ($urandom_range(6, 1)) begin
            cyc();
            if (mem_valid !== 1'b1 || mem_addr !== a0)
                unstable = 1'b1;
        end
        tests_run++;
        if (unstable) begin
            tests_failed++;
            $display("FAIL busy_hold: mem_valid=%b mem_addr=%h expected 1 and %h", mem_valid, mem_addr, a0);
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        model_done = model_done + 16'd1;
        tests_run++;
        if (irq !== 1'b1 || mem_valid !== 1'b0 || status[15:0] !== model_done) begin
            tests_failed++;
            $display("FAIL completion: irq=%b mem_valid=%b done=%h expected 1 0 %h",
                     irq, mem_valid, status[15:0], model_done);
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        bit launched;
        launched = 1'b0;
        repeat (n) begin
            cyc();
            if (mem_valid !== 1'b0)
                launched = 1'b1;
        end
        tests_run++;
        if (launched || status !== exp_status()) begin
            tests_failed++;
            $display("FAIL %s: launched=%b status=%h expected 0 and %h", name, launched, status, exp_status());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        model_reset();
        tests_run++;
        if (status !== 32'd0 || mem_valid !== 1'b0 || mem_addr !== 32'd0 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: status=%h mem_valid=%b mem_addr=%h irq=%b expected all 0",
                     status, mem_valid, mem_addr, irq);
        end
    endtask

    task automatic test_single();
        bit unstable;
        unstable = 1'b0;
        host_ctrl(1'b1, 1'b0);
        host_push(32'h1000_0007);
        cyc();
        tests_run++;
        if (mem_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early: mem_valid=%b expected 0", mem_valid);
        end
        cyc();
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h1000_0000) begin
            tests_failed++;
            $display("FAIL latency3: mem_valid=%b mem_addr=%h expected 1 10000000", mem_valid, mem_addr);
        end
        void'(model_q.pop_front());
        repeat (20) begin
            cyc();
            if (mem_valid !== 1'b1 || mem_addr !== 32'h1000_0000)
                unstable = 1'b1;
        end
        tests_run++;
        if (unstable) begin
            tests_failed++;
            $display("FAIL single_hold: mem_valid=%b mem_addr=%h expected 1 10000000", mem_valid, mem_addr);
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        model_done = model_done + 16'd1;
        tests_run++;
        if (irq !== 1'b1 || status[15:0] !== 16'd1) begin
            tests_failed++;
            $display("FAIL single_irq: irq=%b done=%h expected 1 0001", irq, status[15:0]);
        end
        cyc();
        tests_run++;
        if (irq !== 1'b0 || status !== exp_status()) begin
            tests_failed++;
            $display("FAIL single_idle: irq=%b status=%h expected 0 %h", irq, status, exp_status());
        end
    endtask

    task automatic test_order();
        host_ctrl(1'b0, 1'b0);
        host_push(32'h100);
        host_push(32'h200);
        write_reg(8'(BASE + 2), 32'hBAD0_0000);
        host_push(32'h300);
        expect_quiet("disabled_queue", 6);
        host_ctrl(1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            serve_one(i != 0);
        expect_quiet("order_drained", 8);
    endtask

    task automatic test_random();
        int n;
        n = $urandom_range(10, 2);
        host_ctrl(1'b0, 1'b0);
        for (int i = 0; i < n; i++)
            host_push($urandom);
        expect_quiet("random_queued", 3);
        host_ctrl(1'b1, 1'b0);
        for (int i = 0; i < n; i++)
            serve_one(i != 0);
        expect_quiet("random_drained", 8);
    endtask

    task automatic test_overflow();
        host_ctrl(1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            host_push({$urandom_range(32'hFFFF, 1), 16'h0000} | 32'(i * 8));
        tests_run++;
        if (status[31] !== 1'b0 || status[23:16] !== 8'd16) begin
            tests_failed++;
            $display("FAIL fill16: ovf=%b occ=%0d expected 0 16", status[31], status[23:16]);
        end
        host_push(32'hFFFF_FFF8);
        tests_run++;
        if (status[31] !== 1'b1 || status[23:16] !== 8'd16) begin
            tests_failed++;
            $display("FAIL overflow: ovf=%b occ=%0d expected 1 16", status[31], status[23:16]);
        end
        host_ctrl(1'b1, 1'b0);
        for (int i = 0; i < 16; i++)
            serve_one(i != 0);
        expect_quiet("no_17th", 10);
    endtask

    task automatic test_clear();
        int w;
        host_ctrl(1'b0, 1'b1);
        host_push(32'h400);
        for (int i = 0; i < 4; i++)
            host_push($urandom);
        host_ctrl(1'b1, 1'b0);
        w = 0;
        while (mem_valid !== 1'b1 && w < 50) begin
            w++;
            cyc();
        end
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h400) begin
            tests_failed++;
            $display("FAIL clear_launch: mem_valid=%b mem_addr=%h expected 1 00000400", mem_valid, mem_addr);
        end
        void'(model_q.pop_front());
        host_ctrl(1'b0, 1'b1);
        tests_run++;
        if (status !== 32'h4000_0000 || mem_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_flush: status=%h mem_valid=%b expected 40000000 1", status, mem_valid);
        end
        repeat (5) cyc();
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h400) begin
            tests_failed++;
            $display("FAIL clear_inflight: mem_valid=%b mem_addr=%h expected 1 00000400", mem_valid, mem_addr);
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        model_done = model_done + 16'd1;
        tests_run++;
        if (irq !== 1'b1 || status[15:0] !== 16'd1) begin
            tests_failed++;
            $display("FAIL clear_count: irq=%b done=%h expected 1 0001", irq, status[15:0]);
        end
        expect_quiet("clear_no_launch", 10);
    endtask

    task automatic test_idle_ack_and_wrap();
        host_ctrl(1'b0, 1'b0);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        tests_run++;
        if (irq !== 1'b0 || status[15:0] !== model_done) begin
            tests_failed++;
            $display("FAIL idle_ack: irq=%b done=%h expected 0 %h", irq, status[15:0], model_done);
        end
        cyc();
        force dut.done_count = 16'hFFFF;
        cyc();
        release dut.done_count;
        model_done = 16'hFFFF;
        host_push($urandom);
        host_ctrl(1'b1, 1'b0);
        serve_one(1'b0);
        tests_run++;
        if (status[15:0] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap: done=%h expected 0000", status[15:0]);
        end
    endtask

    task automatic test_rst_busy();
        int w;
        host_ctrl(1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            host_push($urandom);
        host_ctrl(1'b1, 1'b0);
        w = 0;
        while (mem_valid !== 1'b1 && w < 50) begin
            w++;
            cyc();
        end
        tests_run++;
        if (mem_valid !== 1'b1 || status[23:16] !== 8'd2) begin
            tests_failed++;
            $display("FAIL rst_setup: mem_valid=%b occ=%0d expected 1 2", mem_valid, status[23:16]);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        tests_run++;
        if (mem_valid !== 1'b0 || status !== 32'd0 || mem_addr !== 32'd0 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_busy: mem_valid=%b status=%h mem_addr=%h irq=%b expected all 0",
                     mem_valid, status, mem_addr, irq);
        end
        expect_quiet("rst_quiet", 6);
    endtask

    initial begin
        rst      = 1'b1;
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
        mem_ack  = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_order();
        test_random();
        test_overflow();
        test_clear();
        test_idle_ack_and_wrap();
        test_rst_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
